// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants and helpers shared by the VGA sync path.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam bit SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;
    // One spare bit so window bounds equal to 2**COORD_W stay representable.
    typedef logic [COORD_W:0]   coord_ext_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_window(input coord_ext_t val, input coord_ext_t lo, input coord_ext_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable; wrap flags the enabled cycle that returns it to zero.
module vga_mod_counter #(
    parameter int N       = 2,
    parameter int W       = 1,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_reg;

    assign wrap = en && (cnt_reg == LAST);
    assign cnt  = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= W'(RST_VAL);
        end else if (en) begin
            cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: pixel-rate divider, h/v counters and registered sync/blank decode.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    output logic               hsync,
    output logic               vsync,
    output logic               pxl_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_pulse,
    output logic               pix_tick
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam coord_ext_t HS_START = coord_ext_t'(H_ACTIVE + H_FP);
    localparam coord_ext_t HS_END   = coord_ext_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_ext_t VS_START = coord_ext_t'(V_ACTIVE + V_FP);
    localparam coord_ext_t VS_END   = coord_ext_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam coord_ext_t H_ACT    = coord_ext_t'(H_ACTIVE);
    localparam coord_ext_t V_ACT    = coord_ext_t'(V_ACTIVE);

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit the coordinate counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be 1..8");
    end

    // The divider phase itself is never needed; only its wrap (the pixel tick) is.
    logic [DIV_W-1:0] div_cnt_unused;
    logic             tick;
    coord_t           h_cnt, v_cnt;
    logic             h_wrap, v_wrap;

    vga_mod_counter #(.N(CLK_DIV), .W(DIV_W), .RST_VAL(0)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .cnt  (div_cnt_unused),
        .wrap (tick)
    );

    vga_mod_counter #(.N(H_TOTAL), .W(COORD_W), .RST_VAL(H_TOTAL - 1)) u_h (
        .clk  (clk),
        .rst  (rst),
        .en   (tick),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    vga_mod_counter #(.N(V_TOTAL), .W(COORD_W), .RST_VAL(V_TOTAL - 1)) u_v (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    // Decode from the values the counters take on this edge so outputs track them with no lag.
    coord_t h_next, v_next;
    logic   hsync_next, vsync_next, pxl_en_next, frame_pulse_next;

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (tick) begin
            h_next = h_wrap ? '0 : h_cnt + 1'b1;
        end
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    assign hsync_next       = in_window({1'b0, h_next}, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync_next       = in_window({1'b0, v_next}, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    assign pxl_en_next      = ({1'b0, h_next} < H_ACT) && ({1'b0, v_next} < V_ACT);
    assign frame_pulse_next = h_wrap && ({1'b0, v_next} == V_ACT);

    logic hsync_reg, vsync_reg, pxl_en_reg, frame_pulse_reg, pix_tick_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            pxl_en_reg      <= 1'b0;
            frame_pulse_reg <= 1'b0;
            pix_tick_reg    <= 1'b0;
        end else begin
            pix_tick_reg    <= tick;
            frame_pulse_reg <= frame_pulse_next;
            if (tick) begin
                hsync_reg  <= hsync_next;
                vsync_reg  <= vsync_next;
                pxl_en_reg <= pxl_en_next;
            end
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign pxl_en      = pxl_en_reg;
    assign x           = h_cnt;
    assign y           = v_cnt;
    assign frame_pulse = frame_pulse_reg;
    assign pix_tick    = pix_tick_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 800x525 instance plus two shrunken-timing instances.
module tb_vga_sync_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       pe;
        logic       fp;
        logic       pt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       d_hs, d_vs, d_pe, d_fp, d_pt;
    logic [9:0] d_x, d_y;
    logic       a_hs, a_vs, a_pe, a_fp, a_pt;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_pe, b_fp, b_pt;
    logic [9:0] b_x, b_y;

    vga_sync_gen u_def (
        .clk(clk), .rst(rst), .hsync(d_hs), .vsync(d_vs), .pxl_en(d_pe),
        .x(d_x), .y(d_y), .frame_pulse(d_fp), .pix_tick(d_pt)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .pxl_en(a_pe),
        .x(a_x), .y(a_y), .frame_pulse(a_fp), .pix_tick(a_pt)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs), .pxl_en(b_pe),
        .x(b_x), .y(b_y), .frame_pulse(b_fp), .pix_tick(b_pt)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {a_x, a_y, a_hs, a_vs, a_pe, a_fp, a_pt};
    assign obs_b = {b_x, b_y, b_hs, b_vs, b_pe, b_fp, b_pt};

    // Reference: position from the number of ticks since reset, then the decode rules.
    function automatic obs_t model(input int n, input int div, input bit pol);
        obs_t e;
        int   k, idx, h, v;
        k   = n / div;
        idx = (k == 0) ? HT * VT - 1 : (k - 1) % (HT * VT);
        h   = idx % HT;
        v   = idx / HT;
        e.x  = 10'(h);
        e.y  = 10'(v);
        e.hs = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
        e.vs = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
        e.pe = (h < HA) && (v < VA);
        e.pt = (n > 0) && (n % div == 0);
        e.fp = e.pt && (h == 0) && (v == VA);
        return e;
    endfunction

    int   n_edges = 0;
    bit   sb_en   = 1'b0;
    obs_t q_a[$];
    obs_t q_b[$];

    always @(posedge clk) begin
        n_edges <= rst ? 0 : n_edges + 1;
        if (sb_en) begin
            q_a.push_back(model(rst ? 0 : n_edges + 1, 2, 1'b0));
            q_b.push_back(model(rst ? 0 : n_edges + 1, 1, 1'b1));
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({d_x, d_y, d_hs, d_vs, d_pe, d_fp, d_pt} !== {10'd799, 10'd524, 5'b11000}) begin
            tests_failed++;
            $display("FAIL reset_def got x=%0d y=%0d hs=%b vs=%b pe=%b fp=%b pt=%b want 799 524 1 1 0 0 0",
                     d_x, d_y, d_hs, d_vs, d_pe, d_fp, d_pt);
        end
        tests_run++;
        if (obs_a !== {10'(HT - 1), 10'(VT - 1), 5'b11000}) begin
            tests_failed++;
            $display("FAIL reset_a got %h want %h", obs_a, {10'(HT - 1), 10'(VT - 1), 5'b11000});
        end
        tests_run++;
        if (obs_b !== {10'(HT - 1), 10'(VT - 1), 5'b00000}) begin
            tests_failed++;
            $display("FAIL reset_b got %h want %h", obs_b, {10'(HT - 1), 10'(VT - 1), 5'b00000});
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_first_tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (d_x !== 10'd799 || d_pt !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_edge1_def got x=%0d pt=%b want x=799 pt=0", d_x, d_pt);
        end
        tests_run++;
        if (obs_b !== {10'd0, 10'd0, 5'b00101}) begin
            tests_failed++;
            $display("FAIL first_edge1_b got %h want %h", obs_b, {10'd0, 10'd0, 5'b00101});
        end
        @(negedge clk);
        tests_run++;
        if ({d_x, d_y, d_hs, d_vs, d_pe, d_fp, d_pt} !== {10'd0, 10'd0, 5'b11101}) begin
            tests_failed++;
            $display("FAIL first_edge2_def got x=%0d y=%0d hs=%b vs=%b pe=%b fp=%b pt=%b want 0 0 1 1 1 0 1",
                     d_x, d_y, d_hs, d_vs, d_pe, d_fp, d_pt);
        end
        tests_run++;
        if (obs_a !== {10'd0, 10'd0, 5'b11101}) begin
            tests_failed++;
            $display("FAIL first_edge2_a got %h want %h", obs_a, {10'd0, 10'd0, 5'b11101});
        end
        @(negedge clk);
        tests_run++;
        if (d_x !== 10'd0 || d_pt !== 1'b0 || d_pe !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_edge3_def got x=%0d pt=%b pe=%b want x=0 pt=0 pe=1", d_x, d_pt, d_pe);
        end
        @(negedge clk);
        tests_run++;
        if (d_x !== 10'd1 || d_pt !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_edge4_def got x=%0d pt=%b want x=1 pt=1", d_x, d_pt);
        end
        $display("[TB] test_first_tick done");
    endtask

    task automatic test_line();
        int guard = 0;
        int hs_clk = 0, hs_ticks = 0, hs_min = 1023, hs_max = -1;
        int pe_ticks = 0, pe_max = -1, pe_bad = 0;
        while (!(d_pt && d_x == 10'd0 && d_y == 10'd1) && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (guard >= 4000) begin
            tests_failed++;
            $display("FAIL line_start_timeout got x=%0d y=%0d want x=0 y=1", d_x, d_y);
        end
        guard = 0;
        do begin
            if (d_hs == 1'b0) hs_clk++;
            if (d_pe && d_x >= 10'd640) pe_bad++;
            if (d_pt) begin
                if (d_hs == 1'b0) begin
                    hs_ticks++;
                    if (int'(d_x) < hs_min) hs_min = int'(d_x);
                    if (int'(d_x) > hs_max) hs_max = int'(d_x);
                end
                if (d_pe) begin
                    pe_ticks++;
                    if (int'(d_x) > pe_max) pe_max = int'(d_x);
                end
            end
            @(negedge clk);
            guard++;
        end while (!(d_pt && d_x == 10'd0 && d_y == 10'd2) && guard < 4000);
        tests_run++;
        if (guard >= 4000) begin
            tests_failed++;
            $display("FAIL line_end_timeout got x=%0d y=%0d want x=0 y=2", d_x, d_y);
        end
        tests_run++;
        if (hs_ticks != 96 || hs_clk != 192) begin
            tests_failed++;
            $display("FAIL line_hsync_width got ticks=%0d clks=%0d want 96 192", hs_ticks, hs_clk);
        end
        tests_run++;
        if (hs_min != 656 || hs_max != 751) begin
            tests_failed++;
            $display("FAIL line_hsync_span got %0d..%0d want 656..751", hs_min, hs_max);
        end
        tests_run++;
        if (pe_ticks != 640 || pe_max != 639 || pe_bad != 0) begin
            tests_failed++;
            $display("FAIL line_pxl_en got ticks=%0d max_x=%0d bad=%0d want 640 639 0", pe_ticks, pe_max, pe_bad);
        end
        $display("[TB] test_line done");
    endtask

    task automatic test_frame();
        int a_last = -1, b_last = -1, a_pulses = 0, b_pulses = 0;
        int a_space_bad = 0, b_space_bad = 0, a_pos_bad = 0;
        int a_vs_bad = 0, a_hs_bad = 0, b_hs_bad = 0, b_pt_bad = 0, b_vs_move = 0;
        logic b_vs_prev;
        @(negedge clk);
        b_vs_prev = b_vs;
        for (int i = 0; i < 2600; i++) begin
            @(negedge clk);
            if ((a_vs == 1'b0) != (a_y >= 10'(VA + VF) && a_y < 10'(VA + VF + VS))) a_vs_bad++;
            if ((a_hs == 1'b0) != (a_x >= 10'(HA + HF) && a_x < 10'(HA + HF + HS))) a_hs_bad++;
            if ((b_hs == 1'b1) != (b_x >= 10'(HA + HF) && b_x < 10'(HA + HF + HS))) b_hs_bad++;
            if (b_pt !== 1'b1) b_pt_bad++;
            if (b_vs !== b_vs_prev && b_x != 10'd0) b_vs_move++;
            b_vs_prev = b_vs;
            if (a_fp) begin
                a_pulses++;
                if (a_x != 10'd0 || a_y != 10'(VA)) a_pos_bad++;
                if (a_last >= 0 && i - a_last != 2 * HT * VT) a_space_bad++;
                a_last = i;
            end
            if (b_fp) begin
                b_pulses++;
                if (b_last >= 0 && i - b_last != HT * VT) b_space_bad++;
                b_last = i;
            end
        end
        tests_run++;
        if (a_pulses < 2 || a_space_bad != 0 || a_pos_bad != 0) begin
            tests_failed++;
            $display("FAIL frame_pulse_a got pulses=%0d spacing_errs=%0d pos_errs=%0d want >=2 0 0",
                     a_pulses, a_space_bad, a_pos_bad);
        end
        tests_run++;
        if (b_pulses < 5 || b_space_bad != 0) begin
            tests_failed++;
            $display("FAIL frame_pulse_b got pulses=%0d spacing_errs=%0d want >=5 0", b_pulses, b_space_bad);
        end
        tests_run++;
        if (a_vs_bad != 0 || a_hs_bad != 0) begin
            tests_failed++;
            $display("FAIL frame_sync_a got vs_errs=%0d hs_errs=%0d want 0 0", a_vs_bad, a_hs_bad);
        end
        tests_run++;
        if (b_hs_bad != 0 || b_vs_move != 0) begin
            tests_failed++;
            $display("FAIL frame_sync_b got hs_errs=%0d vs_off_col0=%0d want 0 0", b_hs_bad, b_vs_move);
        end
        tests_run++;
        if (b_pt_bad != 0) begin
            tests_failed++;
            $display("FAIL frame_pix_tick_b got low_cycles=%0d want 0", b_pt_bad);
        end
        $display("[TB] test_frame done");
    endtask

    task automatic test_scoreboard(input int cycles);
        obs_t ea, eb;
        int   errs_before = tests_failed;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        sb_en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tests_run++;
            if (q_a.size() != 1 || q_b.size() != 1) begin
                tests_failed++;
                $display("FAIL sb_queue got sizes %0d %0d want 1 1", q_a.size(), q_b.size());
                q_a.delete();
                q_b.delete();
            end else begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                tests_run++;
                if (obs_a !== ea) begin
                    tests_failed++;
                    $display("FAIL sb_a cyc=%0d got x=%0d y=%0d hs%b vs%b pe%b fp%b pt%b want x=%0d y=%0d hs%b vs%b pe%b fp%b pt%b",
                             i, a_x, a_y, a_hs, a_vs, a_pe, a_fp, a_pt, ea.x, ea.y, ea.hs, ea.vs, ea.pe, ea.fp, ea.pt);
                end
                tests_run++;
                if (obs_b !== eb) begin
                    tests_failed++;
                    $display("FAIL sb_b cyc=%0d got x=%0d y=%0d hs%b vs%b pe%b fp%b pt%b want x=%0d y=%0d hs%b vs%b pe%b fp%b pt%b",
                             i, b_x, b_y, b_hs, b_vs, b_pe, b_fp, b_pt, eb.x, eb.y, eb.hs, eb.vs, eb.pe, eb.fp, eb.pt);
                end
            end
            tests_run++;
            if ((a_fp && a_pe) || (b_fp && b_pe)) begin
                tests_failed++;
                $display("FAIL sb_fp_with_pxl_en got a=%b%b b=%b%b want no overlap", a_fp, a_pe, b_fp, b_pe);
            end
        end
        sb_en = 1'b0;
        @(negedge clk);
        q_a.delete();
        q_b.delete();
        $display("[TB] test_scoreboard %0d cycles, %0d new errors", cycles, tests_failed - errs_before);
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (!(a_pt && a_x == 10'd5 && a_y == 10'd3) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (guard >= 2000) begin
            tests_failed++;
            $display("FAIL mid_reset_seek_timeout got x=%0d y=%0d want x=5 y=3", a_x, a_y);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (obs_a !== {10'(HT - 1), 10'(VT - 1), 5'b11000}) begin
            tests_failed++;
            $display("FAIL mid_reset_a got %h want %h", obs_a, {10'(HT - 1), 10'(VT - 1), 5'b11000});
        end
        tests_run++;
        if ({d_x, d_y, d_hs, d_vs, d_pe, d_fp, d_pt} !== {10'd799, 10'd524, 5'b11000}) begin
            tests_failed++;
            $display("FAIL mid_reset_def got x=%0d y=%0d pe=%b pt=%b want 799 524 0 0", d_x, d_y, d_pe, d_pt);
        end
        @(negedge clk);
        tests_run++;
        if (a_x !== 10'(HT - 1) || a_pt !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_edge1_a got x=%0d pt=%b want x=%0d pt=0", a_x, a_pt, HT - 1);
        end
        @(negedge clk);
        tests_run++;
        if (obs_a !== {10'd0, 10'd0, 5'b11101}) begin
            tests_failed++;
            $display("FAIL mid_reset_edge2_a got %h want %h", obs_a, {10'd0, 10'd0, 5'b11101});
        end
        $display("[TB] test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_frame();
        test_scoreboard(3 * 2 * HT * VT + 20);
        test_mid_reset();
        test_scoreboard(1200);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
